// File: rtl/sc_scbc_ulpi_pkg.sv
// Shared types and constants for the ULPI register-access engine.
package sc_scbc_ulpi_pkg;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  localparam logic [1:0] REGWR = 2'b10;
  localparam logic [1:0] REGRD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TXCMD,
    S_WDATA,
    S_WSTP,
    S_RTURN,
    S_RDATA,
    S_REND,
    S_ABORT
  } state_t;
endpackage

// File: rtl/sc_scbc_ulpi_regacc.sv
// ULPI RegWrite/RegRead engine in the ULPICLK domain, with PHY-abort retry.
// Optional NXT-wait timeout with sticky REG_TOUT: define SC_SCBC_ULPI_REG_TIMEOUT_EN.
module sc_scbc_ulpi_regacc
  import sc_scbc_ulpi_pkg::*;
#(
  parameter int TOUT_CYC = 255
) (
  input  logic              ULPICLK,
  input  logic              ULPIRST,
  input  logic              REG_WENB,
  input  logic              REG_RENB,
  input  logic [ADDR_W-1:0] REG_ADDR,
  input  logic [DATA_W-1:0] REG_WDATA,
  output logic [DATA_W-1:0] REG_RDATA,
  output logic              REG_WCOMP,
  output logic              REG_RCOMP,
  output logic              REG_BUSY,
`ifdef SC_SCBC_ULPI_REG_TIMEOUT_EN
  output logic              REG_TOUT,
`endif
  input  logic              ULPI_DIR,
  input  logic              ULPI_NXT,
  input  logic [DATA_W-1:0] ULPI_DATA_I,
  output logic [DATA_W-1:0] ULPI_DATA_O,
  output logic              ULPI_DATA_OE,
  output logic              ULPI_STP
);

  state_t            state, nxt_state;
  logic              wr_pend, rd_pend, is_rd;
  logic              wr_clr, rd_clr;
  logic [DATA_W-1:0] rdata_q;
  logic              oe_int, stp, wcomp, rcomp;
  logic [DATA_W-1:0] data_o;
  logic              tout_hit, to_stp;

`ifdef SC_SCBC_ULPI_REG_TIMEOUT_EN
  localparam int TW = 16;
  logic [TW-1:0] cnt;
  logic          waiting;
  logic          tout_q;

  assign waiting  = (state == S_TXCMD || state == S_WDATA) && !ULPI_NXT && !ULPI_DIR;
  assign tout_hit = waiting && (cnt == TW'(TOUT_CYC - 1));

  always_ff @(posedge ULPICLK) begin
    if (ULPIRST) begin
      cnt    <= '0;
      to_stp <= 1'b0;
      tout_q <= 1'b0;
    end else begin
      cnt    <= (waiting && !tout_hit) ? cnt + 1'b1 : '0;
      // to_stp marks the WSTP cycle that follows a timeout, suppressing WCOMP
      to_stp <= tout_hit;
      if (tout_hit)                 tout_q <= 1'b1;
      else if (REG_WENB || REG_RENB) tout_q <= 1'b0;
    end
  end

  assign REG_TOUT = tout_q;
`else
  logic unused_tout;
  assign unused_tout = (TOUT_CYC != 0);
  assign tout_hit    = 1'b0;
  assign to_stp      = 1'b0;
`endif

  always_comb begin
    nxt_state = state;
    oe_int    = 1'b0;
    data_o    = '0;
    stp       = 1'b0;
    wcomp     = 1'b0;
    rcomp     = 1'b0;
    wr_clr    = 1'b0;
    rd_clr    = 1'b0;
    case (state)
      S_IDLE:
        if (!ULPI_DIR && (wr_pend || rd_pend)) nxt_state = S_TXCMD;
      S_TXCMD: begin
        oe_int = 1'b1;
        data_o = {(is_rd ? REGRD : REGWR), REG_ADDR};
        if (ULPI_DIR)      nxt_state = S_ABORT;
        else if (ULPI_NXT) nxt_state = is_rd ? S_RTURN : S_WDATA;
        else if (tout_hit) nxt_state = S_WSTP;
      end
      S_WDATA: begin
        oe_int = 1'b1;
        data_o = REG_WDATA;
        if (ULPI_DIR)      nxt_state = S_ABORT;
        else if (ULPI_NXT) nxt_state = S_WSTP;
        else if (tout_hit) nxt_state = S_WSTP;
      end
      S_WSTP: begin
        // also reached by a timed-out read's TXCMD, so the flag to drop follows is_rd
        oe_int    = 1'b1;
        stp       = 1'b1;
        wcomp     = !is_rd && !to_stp;
        wr_clr    = !is_rd;
        rd_clr    = is_rd;
        nxt_state = S_IDLE;
      end
      S_RTURN:
        if (ULPI_DIR) nxt_state = ULPI_NXT ? S_ABORT : S_RDATA;
      S_RDATA: begin
        rcomp     = 1'b1;
        rd_clr    = 1'b1;
        nxt_state = S_REND;
      end
      S_REND, S_ABORT:
        if (!ULPI_DIR) nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge ULPICLK) begin
    if (ULPIRST) begin
      state   <= S_IDLE;
      wr_pend <= 1'b0;
      rd_pend <= 1'b0;
      is_rd   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= nxt_state;
      // a pulse coinciding with the clear re-arms the flag for a fresh transaction
      wr_pend <= REG_WENB | (wr_pend & ~wr_clr);
      rd_pend <= REG_RENB | (rd_pend & ~rd_clr);
      if (state == S_IDLE && nxt_state == S_TXCMD) is_rd <= ~wr_pend;
      if (state == S_RDATA) rdata_q <= ULPI_DATA_I;
    end
  end

  // read data is forwarded during RDATA so it is valid alongside RCOMP
  assign REG_RDATA    = (state == S_RDATA) ? ULPI_DATA_I : rdata_q;
  assign REG_WCOMP    = wcomp;
  assign REG_RCOMP    = rcomp;
  assign REG_BUSY     = wr_pend | rd_pend | (state != S_IDLE);
  assign ULPI_DATA_O  = data_o;
  assign ULPI_DATA_OE = oe_int & ~ULPI_DIR;
  assign ULPI_STP     = stp;

endmodule

// File: tb/tb_sc_scbc_ulpi_regacc.sv
// Bench for sc_scbc_ulpi_regacc: a behavioural PHY with a register array drives
// the link, and each scenario checks the bus byte sequence and completion timing.
module tb_sc_scbc_ulpi_regacc;
  logic       clk = 1'b0, rst = 1'b1;
  logic       wenb = 1'b0, renb = 1'b0;
  logic [5:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       dir = 1'b0, nxt = 1'b0;
  logic [7:0] di = '0;
  logic [7:0] rdata, dout;
  logic       wcomp, rcomp, busy, oe, stp;
`ifdef SC_SCBC_ULPI_REG_TIMEOUT_EN
  logic       tout;
`endif

  int ncmp = 0, nerr = 0;
  logic [7:0]  phy_regs [64];
  logic [12:0] obs, exp;
  logic [4:0]  obs5, exp5;

  always #5 clk = ~clk;

  sc_scbc_ulpi_regacc #(.TOUT_CYC(8)) dut (
    .ULPICLK(clk), .ULPIRST(rst),
    .REG_WENB(wenb), .REG_RENB(renb), .REG_ADDR(addr), .REG_WDATA(wdata),
    .REG_RDATA(rdata), .REG_WCOMP(wcomp), .REG_RCOMP(rcomp), .REG_BUSY(busy),
`ifdef SC_SCBC_ULPI_REG_TIMEOUT_EN
    .REG_TOUT(tout),
`endif
    .ULPI_DIR(dir), .ULPI_NXT(nxt), .ULPI_DATA_I(di),
    .ULPI_DATA_O(dout), .ULPI_DATA_OE(oe), .ULPI_STP(stp)
  );

  always @(negedge clk) if (!rst) begin
    ncmp++;
    if (wcomp && rcomp) begin nerr++; $display("FAIL comp_overlap: wcomp=%b rcomp=%b required not both", wcomp, rcomp); end
  end

  task automatic tick; @(posedge clk); #1; endtask

  // starts in the first TXCMD cycle; ends after the WSTP edge
  task automatic run_write_phases(input logic [5:0] a, input logic [7:0] d, input int d1, input int d2, input bit rearm);
    for (int k = 0; k <= d1; k++) begin
      dir = 0; nxt = (k == d1); #1;
      obs = {oe, stp, wcomp, rcomp, busy, dout}; exp = {5'b10001, 2'b10, a}; ncmp++;
      if (obs !== exp) begin nerr++; $display("FAIL wr_txcmd: got %h required %h", obs, exp); end
      tick;
    end
    for (int k = 0; k <= d2; k++) begin
      nxt = (k == d2); #1;
      obs = {oe, stp, wcomp, rcomp, busy, dout}; exp = {5'b10001, d}; ncmp++;
      if (obs !== exp) begin nerr++; $display("FAIL wr_data: got %h required %h", obs, exp); end
      tick;
    end
    nxt = 0; wenb = rearm; #1;
    obs = {oe, stp, wcomp, rcomp, busy, dout}; exp = {5'b11101, 8'h00}; ncmp++;
    if (obs !== exp) begin nerr++; $display("FAIL wr_stp: got %h required %h", obs, exp); end
    phy_regs[a] = d;
    tick; wenb = 0;
  endtask

  // starts in the first TXCMD cycle; ends after the REND->IDLE edge
  task automatic run_read_phases(input logic [5:0] a, input int d1, input int h);
    for (int k = 0; k <= d1; k++) begin
      dir = 0; nxt = (k == d1); #1;
      obs = {oe, stp, wcomp, rcomp, busy, dout}; exp = {5'b10001, 2'b11, a}; ncmp++;
      if (obs !== exp) begin nerr++; $display("FAIL rd_txcmd: got %h required %h", obs, exp); end
      tick;
    end
    dir = 1; nxt = 0; #1;
    obs5 = {oe, stp, wcomp, rcomp, busy}; ncmp++;
    if (obs5 !== 5'b00001) begin nerr++; $display("FAIL rd_turn: got %b required 00001", obs5); end
    tick;
    di = phy_regs[a]; #1;
    obs = {oe, stp, wcomp, rcomp, busy, rdata}; exp = {5'b00011, phy_regs[a]}; ncmp++;
    if (obs !== exp) begin nerr++; $display("FAIL rd_data: got %h required %h", obs, exp); end
    tick;
    di = 8'($urandom);
    for (int k = 0; k <= h; k++) begin
      dir = (k < h); #1;
      obs = {oe, stp, wcomp, rcomp, busy, rdata}; exp = {5'b00001, phy_regs[a]}; ncmp++;
      if (obs !== exp) begin nerr++; $display("FAIL rd_end: got %h required %h", obs, exp); end
      tick;
    end
  endtask

  task automatic chk_idle_after(input string nm);
    #1; obs5 = {oe, stp, wcomp, rcomp, busy}; ncmp++;
    if (obs5 !== 5'b00000) begin nerr++; $display("FAIL %s_idle: got %b required 00000", nm, obs5); end
  endtask

  task automatic pulse(input bit w, input bit r, input logic [5:0] a, input logic [7:0] d);
    addr = a; wdata = d; wenb = w; renb = r; dir = 0; nxt = 0;
    tick; wenb = 0; renb = 0; #1;
    obs5 = {oe, stp, wcomp, rcomp, busy}; ncmp++;
    if (obs5 !== 5'b00001) begin nerr++; $display("FAIL pend: got %b required 00001", obs5); end
    tick;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 64; i++) phy_regs[i] = 8'($urandom);
    rst = 1; tick; tick; #1;
    obs = {oe, stp, wcomp, rcomp, busy, dout}; ncmp++;
    if (obs !== 13'h0 || rdata !== 8'h00) begin nerr++; $display("FAIL reset: got %h/%h required 0/00", obs, rdata); end
    rst = 0; tick;
  endtask

  task automatic test_write_basic;
    pulse(1, 0, 6'h04, 8'h45);
    run_write_phases(6'h04, 8'h45, 0, 0, 0);
    chk_idle_after("wr_basic");
  endtask

  task automatic test_read_basic;
    phy_regs[6'h0A] = 8'h5A;
    pulse(0, 1, 6'h0A, 8'h00);
    run_read_phases(6'h0A, 0, 1);
    chk_idle_after("rd_basic");
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      logic [5:0] a; logic [7:0] d;
      a = 6'($urandom_range(0, 7)); d = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        pulse(1, 0, a, d);
        run_write_phases(a, d, $urandom_range(0, 3), $urandom_range(0, 3), 0);
      end else begin
        pulse(0, 1, a, d);
        run_read_phases(a, $urandom_range(0, 3), $urandom_range(0, 2));
      end
      chk_idle_after("rand");
    end
  endtask

  task automatic test_simultaneous;
    pulse(1, 1, 6'h11, 8'hA7);
    run_write_phases(6'h11, 8'hA7, 0, 1, 0);
    #1; obs5 = {oe, stp, wcomp, rcomp, busy}; ncmp++;
    if (obs5 !== 5'b00001) begin nerr++; $display("FAIL sim_gap: got %b required 00001", obs5); end
    tick;
    run_read_phases(6'h11, 1, 0);
    chk_idle_after("sim");
  endtask

  task automatic test_contention;
    pulse(1, 0, 6'h16, 8'h3C);
    dir = 1; nxt = 0; #1;
    obs5 = {oe, stp, wcomp, rcomp, busy}; ncmp++;
    if (obs5 !== 5'b00001) begin nerr++; $display("FAIL cont_oe_gate: got %b required 00001", obs5); end
    tick;
    for (int k = 0; k < 3; k++) begin
      dir = (k < 2); #1;
      obs5 = {oe, stp, wcomp, rcomp, busy}; ncmp++;
      if (obs5 !== 5'b00001) begin nerr++; $display("FAIL cont_abort: got %b required 00001", obs5); end
      tick;
    end
    #1; obs5 = {oe, stp, wcomp, rcomp, busy}; ncmp++;
    if (obs5 !== 5'b00001) begin nerr++; $display("FAIL cont_retry_idle: got %b required 00001", obs5); end
    tick;
    run_write_phases(6'h16, 8'h3C, 0, 0, 0);
    chk_idle_after("cont");
  endtask

  task automatic test_merge;
    addr = 6'h21; wdata = 8'h99; wenb = 1; tick;
    #1; tick; wenb = 0;
    run_write_phases(6'h21, 8'h99, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      chk_idle_after("merge"); tick;
    end
  endtask

  task automatic test_back_to_back;
    pulse(1, 0, 6'h05, 8'h12);
    run_write_phases(6'h05, 8'h12, 0, 0, 1);
    #1; obs5 = {oe, stp, wcomp, rcomp, busy}; ncmp++;
    if (obs5 !== 5'b00001) begin nerr++; $display("FAIL b2b_rearm: got %b required 00001", obs5); end
    tick;
    run_write_phases(6'h05, 8'h12, 0, 0, 0);
    chk_idle_after("b2b");
  endtask

  task automatic test_reset_midop;
    pulse(1, 0, 6'h33, 8'hE1);
    nxt = 1; tick; nxt = 0;
    rst = 1; tick; rst = 0; #1;
    obs = {oe, stp, wcomp, rcomp, busy, dout}; ncmp++;
    if (obs !== 13'h0 || rdata !== 8'h00) begin nerr++; $display("FAIL rst_midop: got %h/%h required 0/00", obs, rdata); end
    for (int k = 0; k < 8; k++) begin
      tick; chk_idle_after("rst_after");
    end
  endtask

`ifdef SC_SCBC_ULPI_REG_TIMEOUT_EN
  task automatic test_timeout;
    pulse(1, 0, 6'h07, 8'h55);
    for (int k = 0; k < 8; k++) begin
      nxt = 0; #1;
      obs5 = {oe, stp, wcomp, rcomp, busy}; ncmp++;
      if (obs5 !== 5'b10001) begin nerr++; $display("FAIL tout_wait: got %b required 10001", obs5); end
      tick;
    end
    #1; obs = {oe, stp, wcomp, rcomp, busy, dout}; ncmp++;
    if (obs !== {5'b11001, 8'h00} || tout !== 1'b1) begin nerr++; $display("FAIL tout_stp: got %h/%b required %h/1", obs, tout, {5'b11001, 8'h00}); end
    tick; #1; ncmp++;
    if (busy !== 1'b0 || tout !== 1'b1) begin nerr++; $display("FAIL tout_sticky: busy=%b tout=%b required 0/1", busy, tout); end
    pulse(1, 0, 6'h07, 8'h55);
    ncmp++;
    if (tout !== 1'b0) begin nerr++; $display("FAIL tout_clear: got %b required 0", tout); end
    run_write_phases(6'h07, 8'h55, 0, 0, 0);
    chk_idle_after("tout");
  endtask
`endif

  initial begin
    test_reset;
    test_write_basic;
    test_read_basic;
    test_random;
    test_simultaneous;
    test_contention;
    test_merge;
    test_back_to_back;
    test_read_basic;
    test_reset_midop;
`ifdef SC_SCBC_ULPI_REG_TIMEOUT_EN
    test_timeout;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
